// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_sequencer
// Purpose  : Game-flow FSM (IDLE/PLAY/PAUSE/OVER/WIN) for a snake-style game.
//            Generates the frame-paced move tick, the game-logic reset pulse,
//            the freeze flag, overlay enables and the score-dependent period.
// Revision : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int BASE_FRAMES = 20,
  parameter int STEP_FRAMES = 1,
  parameter int MIN_FRAMES  = 4,
  parameter int RST_CYCLES  = 16
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       start_req,
  input  logic       pause_req,
  input  logic       restart_req,
  input  logic       game_over_in,
  input  logic       victory_in,
  input  logic [3:0] score,
  output logic [2:0] state,
  output logic       move_tick,
  output logic       game_rst,
  output logic       freeze,
  output logic       show_game_over,
  output logic       show_you_win,
  output logic       show_score,
  output logic [5:0] period
);

  localparam int c_RST_CNT_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    OVER  = 3'd3,
    WIN   = 3'd4
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_live;
  logic                     r_start_d;
  logic                     r_pause_d;
  logic                     r_restart_d;
  logic                     r_vblnk_d;
  logic [5:0]               r_frame_cnt;
  logic [5:0]               r_period;
  logic [c_RST_CNT_W-1:0]   r_rst_cnt;
  logic                     r_game_rst;
  logic                     r_move_tick;
  logic                     r_freeze;
  logic                     r_show_go;
  logic                     r_show_win;
  logic                     r_show_score;

  logic                     w_start_ev;
  logic                     w_pause_ev;
  logic                     w_restart_ev;
  logic                     w_frame_edge;
  logic                     w_stay_play;
  logic [6:0]               w_cnt_inc;
  logic                     w_tick;
  logic [15:0]              w_prod;
  logic [7:0]               w_period_calc;

  // Request edges are masked for the first cycle after reset so that a key
  // held through reset has to be released and pressed again.
  assign w_start_ev   = r_live & start_req   & ~r_start_d;
  assign w_pause_ev   = r_live & pause_req   & ~r_pause_d;
  assign w_restart_ev = r_live & restart_req & ~r_restart_d;
  assign w_frame_edge = vblnk & ~r_vblnk_d;

  // Delay registers for edge detection plus the post-reset arming flag.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_live      <= 1'b0;
      r_start_d   <= 1'b0;
      r_pause_d   <= 1'b0;
      r_restart_d <= 1'b0;
      r_vblnk_d   <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_start_d   <= start_req;
      r_pause_d   <= pause_req;
      r_restart_d <= restart_req;
      r_vblnk_d   <= vblnk;
    end
  end

  // Next-state decode; restart beats victory, then game over, pause, start.
  always_comb begin
    w_state_nxt = r_state;
    if (w_restart_ev) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        PLAY: begin
          if (victory_in)        w_state_nxt = WIN;
          else if (game_over_in) w_state_nxt = OVER;
          else if (w_pause_ev)   w_state_nxt = PAUSE;
        end
        PAUSE: begin
          if (w_pause_ev || w_start_ev) w_state_nxt = PLAY;
        end
        IDLE: begin
          if (w_start_ev && !r_game_rst) w_state_nxt = PLAY;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // A tick only fires when PLAY is held through the frame edge, so it can
  // never show up alongside a state that has just left PLAY.
  assign w_stay_play = (r_state == PLAY) && (w_state_nxt == PLAY);
  assign w_cnt_inc   = {1'b0, r_frame_cnt} + 7'd1;
  assign w_tick      = w_stay_play && w_frame_edge && (w_cnt_inc >= {1'b0, r_period});

  // Period from score with a floor at MIN_FRAMES; the floor test is done
  // before subtracting so the difference can never wrap.
  always_comb begin
    w_prod        = 16'(score) * 16'(STEP_FRAMES);
    w_period_calc = 8'(BASE_FRAMES);
    if ((w_prod + 16'(MIN_FRAMES)) > 16'(BASE_FRAMES)) begin
      w_period_calc = 8'(MIN_FRAMES);
    end else begin
      w_period_calc = 8'(16'(BASE_FRAMES) - w_prod);
    end
  end

  // State register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame counter: cleared on a fresh game and on each tick, frozen in PAUSE.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= 6'd0;
    end else if ((r_state == IDLE) && (w_state_nxt == PLAY)) begin
      r_frame_cnt <= 6'd0;
    end else if (w_tick) begin
      r_frame_cnt <= 6'd0;
    end else if (w_stay_play && w_frame_edge) begin
      r_frame_cnt <= r_frame_cnt + 6'd1;
    end
  end

  // Game-logic reset pulse, RST_CYCLES long, launched by every restart.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_game_rst <= 1'b0;
      r_rst_cnt  <= '0;
    end else if (w_restart_ev) begin
      r_game_rst <= 1'b1;
      r_rst_cnt  <= c_RST_CNT_W'(RST_CYCLES - 1);
    end else if (r_game_rst) begin
      if (r_rst_cnt == '0) r_game_rst <= 1'b0;
      else                 r_rst_cnt  <= r_rst_cnt - c_RST_CNT_W'(1);
    end
  end

  // Registered outputs, decoded from the upcoming state.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_period     <= 6'(BASE_FRAMES);
      r_move_tick  <= 1'b0;
      r_freeze     <= 1'b1;
      r_show_go    <= 1'b0;
      r_show_win   <= 1'b0;
      r_show_score <= 1'b0;
    end else begin
      r_period     <= 6'(w_period_calc);
      r_move_tick  <= w_tick;
      r_freeze     <= (w_state_nxt != PLAY);
      r_show_go    <= (w_state_nxt == OVER);
      r_show_win   <= (w_state_nxt == WIN);
      r_show_score <= (w_state_nxt == OVER) || (w_state_nxt == WIN);
    end
  end

  assign state          = r_state;
  assign move_tick      = r_move_tick;
  assign game_rst       = r_game_rst;
  assign freeze         = r_freeze;
  assign show_game_over = r_show_go;
  assign show_you_win   = r_show_win;
  assign show_score     = r_show_score;
  assign period         = r_period;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_sequencer
// Purpose  : Scoreboard bench for game_sequencer. A frame-level game model
//            queues expected state changes, tick frame numbers and game_rst
//            pulse lengths; a monitor pops and compares them as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  localparam int BASE = 20;
  localparam int STEP = 1;
  localparam int MINF = 4;
  localparam int RSTC = 16;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vblnk = 1'b0;
  logic       start_req = 1'b0;
  logic       pause_req = 1'b0;
  logic       restart_req = 1'b0;
  logic       game_over_in = 1'b0;
  logic       victory_in = 1'b0;
  logic [3:0] score = 4'd0;
  logic [2:0] state;
  logic       move_tick, game_rst, freeze, show_game_over, show_you_win, show_score;
  logic [5:0] period;
  logic [2:0] state2;
  logic       move_tick2, game_rst2, freeze2, show_go2, show_win2, show_score2;
  logic [5:0] period2;

  game_sequencer #(.BASE_FRAMES(BASE), .STEP_FRAMES(STEP), .MIN_FRAMES(MINF), .RST_CYCLES(RSTC)) dut (
    .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .start_req(start_req), .pause_req(pause_req),
    .restart_req(restart_req), .game_over_in(game_over_in), .victory_in(victory_in), .score(score),
    .state(state), .move_tick(move_tick), .game_rst(game_rst), .freeze(freeze),
    .show_game_over(show_game_over), .show_you_win(show_you_win), .show_score(show_score),
    .period(period)
  );

  // Second instance with a steeper slope, used for the period clamp.
  game_sequencer #(.BASE_FRAMES(BASE), .STEP_FRAMES(2), .MIN_FRAMES(MINF), .RST_CYCLES(RSTC)) dut2 (
    .pclk(pclk), .rst_n(rst_n), .vblnk(vblnk), .start_req(start_req), .pause_req(pause_req),
    .restart_req(restart_req), .game_over_in(game_over_in), .victory_in(victory_in), .score(score),
    .state(state2), .move_tick(move_tick2), .game_rst(game_rst2), .freeze(freeze2),
    .show_game_over(show_go2), .show_you_win(show_win2), .show_score(show_score2),
    .period(period2)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames = 0;
  int state_q[$];
  int tick_q[$];
  int grst_q[$];
  int m_state = 0;
  int m_count = 0;
  int rst_t = -1000;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d expected=none (t=%0t)", name, act, $time);
  endtask

  // Move period in frames from the game rules.
  function automatic int mper(input int s, input int st);
    if (s * st + MINF > BASE) return MINF;
    return BASE - s * st;
  endfunction

  // Game rules applied to one batch of simultaneous events.
  // ev bits: 0 start, 1 pause, 2 restart, 3 victory, 4 game over.
  task automatic model_event(input int ev);
    int n;
    int t;
    n = m_state;
    t = cyc + 1;
    if ((ev & 4) != 0) begin
      n = 0;
      rst_t = t;
      grst_q.push_back(RSTC);
    end else if (m_state == 1 && (ev & 8) != 0) n = 4;
    else if (m_state == 1 && (ev & 16) != 0) n = 3;
    else if (m_state == 1 && (ev & 2) != 0) n = 2;
    else if (m_state == 2 && (ev & 3) != 0) n = 1;
    else if (m_state == 0 && (ev & 1) != 0 && !((t - rst_t) >= 1 && (t - rst_t) <= RSTC)) begin
      n = 1;
      m_count = 0;
    end
    if (n != m_state) state_q.push_back(n);
    m_state = n;
  endtask

  // One frame has elapsed: in PLAY count it and expect a move when due.
  task automatic model_frame();
    if (m_state == 1) begin
      m_count++;
      if (m_count >= mper(int'(score), STEP)) begin
        tick_q.push_back(frames);
        m_count = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input int ev);
    if ((ev & 1) != 0)  start_req = 1'b1;
    if ((ev & 2) != 0)  pause_req = 1'b1;
    if ((ev & 4) != 0)  restart_req = 1'b1;
    if ((ev & 8) != 0)  victory_in = 1'b1;
    if ((ev & 16) != 0) game_over_in = 1'b1;
    if ((ev & 32) != 0) score = 4'($urandom_range(0, 15));
    if ((ev & 31) != 0) model_event(ev & 31);
  endtask

  task automatic release_all();
    start_req = 1'b0;
    pause_req = 1'b0;
    restart_req = 1'b0;
    victory_in = 1'b0;
    game_over_in = 1'b0;
  endtask

  // 100-cycle frame, vblnk high for 8 lines; events land mid-frame.
  task automatic run_frame(input int ev1, input int ev2);
    vblnk = 1'b1;
    frames++;
    model_frame();
    for (int c = 0; c < 100; c++) begin
      if (c == 8) vblnk = 1'b0;
      if (c == 50 && ev1 != 0) issue(ev1);
      if (c == 53 || c == 59) release_all();
      if (c == 56 && ev2 != 0) issue(ev2);
      step();
    end
    chk("state_pending", state_q.size(), 0);
  endtask

  // Monitor: compares every DUT-presented change against the queues.
  initial begin
    int prev;
    int run;
    int e;
    prev = 0;
    run = 0;
    forever begin
      @(negedge pclk);
      if (int'(state) != prev) begin
        if (state_q.size() == 0) fail("state_unexpected", int'(state));
        else begin
          e = state_q.pop_front();
          chk("state", int'(state), e);
          chk("freeze", int'(freeze), int'(e != 1));
          chk("show_game_over", int'(show_game_over), int'(e == 3));
          chk("show_you_win", int'(show_you_win), int'(e == 4));
          chk("show_score", int'(show_score), int'(e == 3 || e == 4));
        end
        prev = int'(state);
      end
      if (move_tick) begin
        if (tick_q.size() == 0) fail("tick_unexpected", frames);
        else chk("tick_frame", frames, tick_q.pop_front());
        chk("tick_in_play", int'(state), 1);
      end
      if (game_rst) run++;
      else if (run > 0) begin
        if (grst_q.size() == 0) fail("game_rst_unexpected", run);
        else chk("game_rst_len", run, grst_q.pop_front());
        run = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int ev;
    // Reset values.
    repeat (3) step();
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(move_tick), 0);
    chk("rst_game_rst", int'(game_rst), 0);
    chk("rst_freeze", int'(freeze), 1);
    chk("rst_shows", int'({show_game_over, show_you_win, show_score}), 0);
    chk("rst_period", int'(period), BASE);
    chk("rst_period2", int'(period2), BASE);
    rst_n = 1'b1;
    repeat (2) step();

    // Period sweep over all scores for both slopes, one-cycle latency.
    for (int s = 0; s < 16; s++) begin
      score = 4'(s);
      step();
      chk("period_step1", int'(period), mper(s, STEP));
      chk("period_step2", int'(period2), mper(s, 2));
    end
    score = 4'd0;
    step();

    // Nominal pace.
    run_frame(1, 0);
    repeat (44) run_frame(0, 0);

    // Pause at count 7 for 30 frames.
    run_frame(4, 0);
    run_frame(1, 0);
    repeat (6) run_frame(0, 0);
    run_frame(2, 0);
    repeat (29) run_frame(0, 0);
    run_frame(2, 0);
    repeat (15) run_frame(0, 0);

    // Simultaneous end flags: victory wins.
    run_frame(8 | 16, 0);
    run_frame(0, 0);

    // Restart precedence and start lockout during game_rst.
    run_frame(4, 0);
    run_frame(1, 0);
    run_frame(16, 0);
    run_frame(4 | 1, 1);
    run_frame(0, 0);
    run_frame(1, 0);

    // Async reset mid-game with a start key held across release.
    repeat (3) run_frame(0, 0);
    score = 4'd9;
    step();
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    start_req = 1'b1;
    if (m_state != 0) state_q.push_back(0);
    m_state = 0;
    rst_t = -1000;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_tick", int'(move_tick), 0);
    chk("arst_game_rst", int'(game_rst), 0);
    chk("arst_freeze", int'(freeze), 1);
    chk("arst_shows", int'({show_game_over, show_you_win, show_score}), 0);
    chk("arst_period", int'(period), BASE);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    start_req = 1'b0;
    step();
    repeat (2) run_frame(0, 0);
    run_frame(1, 0);

    // Randomized play.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if ((m_state == 3 || m_state == 4) && r <= 5) ev = 4;
      else if (r <= 1) ev = 1;
      else if (r == 2) ev = 2;
      else if (r == 3) ev = 4;
      else if (r == 4) ev = 8;
      else if (r == 5) ev = 16;
      else if (r <= 8) ev = 32;
      else ev = 0;
      run_frame(ev, 0);
    end

    repeat (20) step();
    chk("end_state_q", state_q.size(), 0);
    chk("end_tick_q", tick_q.size(), 0);
    chk("end_grst_q", grst_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
